// File: rtl/alu_result_queue.sv
// Writeback-side FIFO behind the 16-bit ALU: stores result, opcode, dest tag and {C,Z,N,E}.
// Optional sticky flag accumulator is built only when ALU_RESULT_STICKY_EN is defined.
module alu_result_queue #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DEST_W = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         ar_out,
    input  logic                     ar_cout,
    input  logic                     ar_compare,
    input  logic [3:0]               ar_sel,
    input  logic [DEST_W-1:0]        in_dest,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [3:0]               out_sel,
    output logic [DEST_W-1:0]        out_dest,
    output logic [3:0]               out_flags,
    output logic [$clog2(DEPTH):0]   level,
    output logic [3:0]               sticky_flags,
    input  logic                     flag_clr
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]  data_mem  [DEPTH];
    logic [3:0]        sel_mem   [DEPTH];
    logic [DEST_W-1:0] dest_mem  [DEPTH];
    logic [3:0]        flags_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    logic       push;
    logic       pop;
    logic [3:0] new_flags;

    // Handshakes depend only on registered occupancy.
    assign in_ready  = (level_q != LVL_W'(DEPTH));
    assign out_valid = (level_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign level     = level_q;

    assign new_flags = {ar_cout, (ar_out == '0), ar_out[WIDTH-1], ar_compare};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        unique case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is not reset; a push coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            data_mem[wr_ptr_q]  <= ar_out;
            sel_mem[wr_ptr_q]   <= ar_sel;
            dest_mem[wr_ptr_q]  <= in_dest;
            flags_mem[wr_ptr_q] <= new_flags;
        end
    end

    always_comb begin
        out_data  = '0;
        out_sel   = '0;
        out_dest  = '0;
        out_flags = '0;
        if (out_valid) begin
            out_data  = data_mem[rd_ptr_q];
            out_sel   = sel_mem[rd_ptr_q];
            out_dest  = dest_mem[rd_ptr_q];
            out_flags = flags_mem[rd_ptr_q];
        end
    end

`ifdef ALU_RESULT_STICKY_EN
    logic [3:0] sticky_q, sticky_d;

    always_comb begin
        sticky_d = flag_clr ? 4'b0000 : sticky_q;
        if (push) begin
            sticky_d = sticky_d | new_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_flags = sticky_q;
`else
    logic unused_flag_clr;
    assign unused_flag_clr = flag_clr;
    assign sticky_flags    = '0;
`endif

endmodule

// File: tb/tb_alu_result_queue.sv
// Bench for alu_result_queue: table-driven vectors plus a scoreboard of queued entries.
module tb_alu_result_queue;

    localparam int WIDTH  = 16;
    localparam int DEPTH  = 2;
    localparam int DEST_W = 3;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  ar_out;
    logic              ar_cout;
    logic              ar_compare;
    logic [3:0]        ar_sel;
    logic [DEST_W-1:0] in_dest;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [3:0]        out_sel;
    logic [DEST_W-1:0] out_dest;
    logic [3:0]        out_flags;
    logic [1:0]        level;
    logic [3:0]        sticky_flags;
    logic              flag_clr;

    alu_result_queue #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .DEST_W (DEST_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ar_out       (ar_out),
        .ar_cout      (ar_cout),
        .ar_compare   (ar_compare),
        .ar_sel       (ar_sel),
        .in_dest      (in_dest),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_sel      (out_sel),
        .out_dest     (out_dest),
        .out_flags    (out_flags),
        .level        (level),
        .sticky_flags (sticky_flags),
        .flag_clr     (flag_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  s;
        logic [2:0]  dst;
        logic [3:0]  f;
    } ent_t;

    typedef struct {
        logic        iv;
        logic [15:0] d;
        logic        c;
        logic        e;
        logic [3:0]  s;
        logic [2:0]  dst;
        logic        ordy;
        logic        clr;
        int          exp_level;
    } vec_t;

    ent_t sb[$];
    vec_t vecs[$];
    logic [3:0] m_sticky;
    int n_vec;
    int n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [15:0] d, input logic c,
                                input logic e, input logic [3:0] s, input logic [2:0] dst,
                                input logic ordy, input logic clr, input int lvl);
        vec_t v;
        v.iv = iv; v.d = d; v.c = c; v.e = e; v.s = s; v.dst = dst;
        v.ordy = ordy; v.clr = clr; v.exp_level = lvl;
        return v;
    endfunction

    task automatic check_state();
        ent_t head;
        head = (sb.size() != 0) ? sb[0] : '0;
        check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        check("in_ready", 32'(in_ready), 32'(sb.size() != DEPTH));
        check("level", 32'(level), 32'(sb.size()));
        check("head", 32'({out_data, out_sel, out_dest, out_flags}), 32'(head));
        check("sticky_flags", 32'(sticky_flags), 32'(m_sticky));
    endtask

    // Called at a negedge: drive, predict, cross the edge, compare at the next negedge.
    task automatic apply(input vec_t v);
        logic do_push, do_pop;
        ent_t ent;
        in_valid   = v.iv;
        ar_out     = v.d;
        ar_cout    = v.c;
        ar_compare = v.e;
        ar_sel     = v.s;
        in_dest    = v.dst;
        out_ready  = v.ordy;
        flag_clr   = v.clr;
        do_push = v.iv && (sb.size() < DEPTH);
        do_pop  = v.ordy && (sb.size() > 0);
        ent.d   = v.d;
        ent.s   = v.s;
        ent.dst = v.dst;
        ent.f   = {v.c, v.d == 16'h0000, v.d[15], v.e};
        @(posedge clk);
        if (do_pop) void'(sb.pop_front());
        if (do_push) sb.push_back(ent);
`ifdef ALU_RESULT_STICKY_EN
        if (v.clr) m_sticky = 4'b0000;
        if (do_push) m_sticky = m_sticky | ent.f;
`endif
        @(negedge clk);
        check_state();
        check("vec_level", 32'(level), 32'(v.exp_level));
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        ar_out    = 16'h1234;
        flag_clr  = 1'b0;
        @(posedge clk);
        sb.delete();
        m_sticky = 4'b0000;
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        check_state();
        check("reset_level", 32'(level), 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_fail = 0;
        m_sticky = 4'b0000;
        rst_n = 1'b0;
        in_valid = 1'b0; ar_out = '0; ar_cout = 1'b0; ar_compare = 1'b0;
        ar_sel = '0; in_dest = '0; out_ready = 1'b0; flag_clr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        do_reset();
        check("reset_data", 32'(out_data), 32'h0);
        check("reset_flags", 32'(out_flags), 32'h0);

        vecs.push_back(mk(1, 16'h0000, 1, 1, 4'h3, 3'd5, 0, 0, 1));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 4'h0, 3'd0, 1, 0, 0));
        vecs.push_back(mk(1, 16'h8001, 0, 0, 4'h1, 3'd2, 0, 0, 1));
        vecs.push_back(mk(1, 16'h0002, 0, 0, 4'h2, 3'd3, 0, 0, 2));
        vecs.push_back(mk(1, 16'h0003, 1, 0, 4'h4, 3'd4, 0, 0, 2));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 4'h0, 3'd0, 1, 0, 1));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 4'h0, 3'd0, 1, 0, 0));
        vecs.push_back(mk(1, 16'h0005, 0, 1, 4'h7, 3'd1, 1, 0, 1));
        for (int i = 0; i < 8; i++) begin
            vecs.push_back(mk(1, 16'(16'h7ff0 + 16'(i * 16'h1111)), 1'(i), 1'(i >> 1),
                              4'(i + 8), 3'(i), 1, 0, 1));
        end
        vecs.push_back(mk(1, 16'hfffe, 1, 0, 4'h9, 3'd6, 0, 0, 2));
        vecs.push_back(mk(1, 16'h0abc, 0, 1, 4'ha, 3'd7, 1, 0, 1));
        vecs.push_back(mk(1, 16'h0bcd, 0, 0, 4'hb, 3'd2, 0, 0, 2));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 4'h0, 3'd0, 1, 0, 1));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 4'h0, 3'd0, 1, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 0, 0, 4'h0, 3'd0, 1, 0, 0));
        foreach (vecs[i]) apply(vecs[i]);

        // Full-queue head check: 0x8001 stored with N set, then reset mid-stream.
        apply(mk(1, 16'h8001, 0, 0, 4'h5, 3'd4, 0, 0, 1));
        check("n_flag_head", 32'(out_flags), 32'b0010);
        apply(mk(1, 16'h0002, 0, 0, 4'h6, 3'd5, 0, 0, 2));
        do_reset();
        apply(mk(1, 16'h4444, 0, 0, 4'hc, 3'd3, 0, 0, 1));
        check("post_reset_data", 32'(out_data), 32'h4444);
        apply(mk(0, 16'h0000, 0, 0, 4'h0, 3'd0, 1, 0, 0));

`ifdef ALU_RESULT_STICKY_EN
        apply(mk(1, 16'h0010, 1, 0, 4'h1, 3'd1, 1, 0, 1));
        apply(mk(1, 16'h0000, 0, 0, 4'h2, 3'd2, 1, 0, 1));
        check("sticky_cz", 32'(sticky_flags), 32'b1100);
        apply(mk(1, 16'h8001, 0, 0, 4'h3, 3'd3, 1, 1, 1));
        check("sticky_clr_push", 32'(sticky_flags), 32'b0010);
        apply(mk(0, 16'h0000, 0, 0, 4'h0, 3'd0, 1, 1, 0));
        check("sticky_clr", 32'(sticky_flags), 32'b0000);
`else
        apply(mk(1, 16'h0000, 1, 1, 4'h1, 3'd1, 1, 1, 1));
        check("sticky_tied", 32'(sticky_flags), 32'b0000);
        apply(mk(0, 16'h0000, 0, 0, 4'h0, 3'd0, 1, 0, 0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
